// File: rtl/sonar_scheduler_pkg.sv
// Shared state encoding and default 50 MHz timing for the sonar round-robin scheduler.
package sonar_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TRIG   = 3'd1,
        ST_WAIT_R = 3'd2,
        ST_MEAS   = 3'd3,
        ST_GUARD  = 3'd4
    } state_t;

    localparam int DEF_N_SENSORS    = 3;
    localparam int DEF_SEL_W        = 2;
    localparam int DEF_CNT_W        = 22;
    localparam int DEF_TRIG_CYCLES  = 500;
    localparam int DEF_ECHO_TIMEOUT = 1_900_000;
    localparam int DEF_GUARD_CYCLES = 3_000_000;

endpackage

// File: rtl/sonar_scheduler_echo_sync.sv
// Two-flop synchronizer for one raw echo pin.
module sonar_scheduler_echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin trigger/echo controller for N HC-SR04 sensors: trigger, time the echo,
// report the width (or a timeout), then hold a guard pause before the next sensor.
module sonar_scheduler
    import sonar_scheduler_pkg::*;
#(
    parameter int N_SENSORS    = DEF_N_SENSORS,
    parameter int SEL_W        = DEF_SEL_W,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int TRIG_CYCLES  = DEF_TRIG_CYCLES,
    parameter int ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trig,
    output logic                 busy,
    output logic                 meas_valid,
    output logic [SEL_W-1:0]     meas_id,
    output logic [CNT_W-1:0]     meas_width,
    output logic                 meas_timeout
);

    localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST  = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ECHO_FULL  = CNT_W'(ECHO_TIMEOUT);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [SEL_W-1:0] CUR_LAST   = SEL_W'(N_SENSORS - 1);

    logic [N_SENSORS-1:0] echo_s;

    generate
        for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_sync
            sonar_scheduler_echo_sync u_sync (
                .clk   (clk),
                .reset (reset),
                .d     (echo[gi]),
                .q     (echo_s[gi])
            );
        end
    endgenerate

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     cur_q, cur_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 echo_lvl_q, echo_lvl_d;
    logic [N_SENSORS-1:0] trig_q, trig_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [SEL_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]     width_q, width_d;
    logic                 timeout_q, timeout_d;

    logic echo_cur;
    assign echo_cur = echo_s[cur_q];

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q + 1'b1;
        echo_lvl_d = echo_cur;
        valid_d    = 1'b0;
        id_d       = id_q;
        width_d    = width_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_R;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_R: begin
                // Only a fresh rising edge starts a measurement; a level that was already high is ignored.
                if (echo_cur && !echo_lvl_q) begin
                    state_d = ST_MEAS;
                    cnt_d   = '0;
                end else if (cnt_q == ECHO_LAST) begin
                    state_d   = ST_GUARD;
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    id_d      = cur_q;
                    width_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            ST_MEAS: begin
                // The delayed level lines the count up with the edge cycle, so width = cycles high.
                if (!echo_lvl_q) begin
                    state_d   = ST_GUARD;
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    id_d      = cur_q;
                    width_d   = cnt_q;
                    timeout_d = 1'b0;
                end else if (cnt_q == ECHO_LAST) begin
                    state_d   = ST_GUARD;
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    id_d      = cur_q;
                    width_d   = ECHO_FULL;
                    timeout_d = 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    cur_d   = (cur_q == CUR_LAST) ? '0 : cur_q + 1'b1;
                    state_d = enable ? ST_TRIG : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        trig_d = '0;
        if (state_d == ST_TRIG) trig_d[cur_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            cnt_q      <= '0;
            echo_lvl_q <= 1'b0;
            trig_q     <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            width_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            echo_lvl_q <= echo_lvl_d;
            trig_q     <= trig_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            width_q    <= width_d;
            timeout_q  <= timeout_d;
        end
    end

    assign trig         = trig_q;
    assign busy         = busy_q;
    assign meas_valid   = valid_q;
    assign meas_id      = id_q;
    assign meas_width   = width_q;
    assign meas_timeout = timeout_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with a behavioural echo responder per sensor.
`timescale 1ns/1ps
module tb_sonar_scheduler;

    localparam int N        = 3;
    localparam int SEL_W    = 2;
    localparam int CNT_W    = 22;
    localparam int TRIG_C   = 4;
    localparam int ECHO_TO  = 50;
    localparam int GUARD_C  = 8;
    localparam int ECHO_DLY = 20;
    localparam int ECHO_LEN = 10;

    localparam int M_NONE        = 0;
    localparam int M_NORMAL      = 1;
    localparam int M_STUCK_AFTER = 2;
    localparam int M_HIGH        = 3;

    localparam int Q_RES  = 0;
    localparam int Q_RISE = 1;
    localparam int Q_FALL = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [N-1:0]     echo;
    logic [N-1:0]     echo_resp = '0;
    logic [N-1:0]     echo_noise = '0;
    logic [N-1:0]     trig;
    logic             busy;
    logic             meas_valid;
    logic [SEL_W-1:0] meas_id;
    logic [CNT_W-1:0] meas_width;
    logic             meas_timeout;

    assign echo = echo_resp | echo_noise;

    always #5 clk = ~clk;

    sonar_scheduler #(
        .N_SENSORS    (N),
        .SEL_W        (SEL_W),
        .CNT_W        (CNT_W),
        .TRIG_CYCLES  (TRIG_C),
        .ECHO_TIMEOUT (ECHO_TO),
        .GUARD_CYCLES (GUARD_C)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .echo         (echo),
        .trig         (trig),
        .busy         (busy),
        .meas_valid   (meas_valid),
        .meas_id      (meas_id),
        .meas_width   (meas_width),
        .meas_timeout (meas_timeout)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int   mode [N];
    bit   armed [N];
    int   arm_cyc [N];
    int   rise_start [N];
    logic [N-1:0] trig_prev = '0;
    logic busy_prev = 1'b0;
    int   busy_fall_cyc = -1;
    int   overlap_cnt = 0;

    int res_id[$], res_w[$], res_to[$], res_cyc[$];
    int rise_id[$], rise_cyc[$];
    int fall_id[$], fall_len[$], fall_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observer and echo responder: samples on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (meas_valid) begin
            res_id.push_back(int'(meas_id));
            res_w.push_back(int'(meas_width));
            res_to.push_back(int'(meas_timeout));
            res_cyc.push_back(cyc);
            $display("[%0d] result id=%0d width=%0d timeout=%0d", cyc, meas_id, meas_width, meas_timeout);
        end
        if ($countones(trig) > 1) overlap_cnt++;
        if (busy_prev && !busy) busy_fall_cyc = cyc;
        busy_prev = busy;
        for (int i = 0; i < N; i++) begin
            if (trig[i] && !trig_prev[i]) begin
                rise_start[i] = cyc;
                rise_id.push_back(i);
                rise_cyc.push_back(cyc);
                armed[i] = 1'b0;
            end
            if (!trig[i] && trig_prev[i]) begin
                fall_id.push_back(i);
                fall_len.push_back(cyc - rise_start[i]);
                fall_cyc.push_back(cyc);
                armed[i]   = 1'b1;
                arm_cyc[i] = cyc + ECHO_DLY;
            end
            case (mode[i])
                M_NORMAL:      echo_resp[i] = armed[i] && (cyc >= arm_cyc[i]) && (cyc < arm_cyc[i] + ECHO_LEN);
                M_STUCK_AFTER: echo_resp[i] = armed[i] && (cyc >= arm_cyc[i]);
                M_HIGH:        echo_resp[i] = 1'b1;
                default:       echo_resp[i] = 1'b0;
            endcase
        end
        trig_prev = trig;
    end

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        enable     = 1'b0;
        echo_noise = '0;
        repeat (3) @(negedge clk);
        res_id.delete(); res_w.delete(); res_to.delete(); res_cyc.delete();
        rise_id.delete(); rise_cyc.delete();
        fall_id.delete(); fall_len.delete(); fall_cyc.delete();
        reset = 1'b0;
    endtask

    task automatic set_modes(input int m0, input int m1, input int m2);
        mode[0] = m0;
        mode[1] = m1;
        mode[2] = m2;
    endtask

    task automatic wait_for(input int sel, input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if ((sel == Q_RES && res_id.size() >= n) ||
                (sel == Q_RISE && rise_id.size() >= n) ||
                (sel == Q_FALL && fall_id.size() >= n)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (trig !== 3'b000) begin miscompares++; $display("FAIL reset_trig: got %b expected 000", trig); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if ({meas_valid, meas_timeout} !== 2'b00) begin
            miscompares++; $display("FAIL reset_flags: got valid=%b timeout=%b expected 0 0", meas_valid, meas_timeout);
        end
        vectors++;
        if (meas_id !== '0 || meas_width !== '0) begin
            miscompares++; $display("FAIL reset_fields: got id=%0d width=%0d expected 0 0", meas_id, meas_width);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rise_id.size() != 0) begin
            miscompares++; $display("FAIL idle_hold: got busy=%b trigs=%0d expected 0 0", busy, rise_id.size());
        end
    endtask

    task automatic test_round_robin();
        bit ok_r, ok_f;
        do_reset();
        set_modes(M_NORMAL, M_NORMAL, M_NORMAL);
        enable = 1'b1;
        wait_for(Q_RES, 3, ok_r);
        wait_for(Q_FALL, 4, ok_f);
        enable = 1'b0;
        vectors++;
        if (!(ok_r && ok_f)) begin
            miscompares++; $display("FAIL rr_wait: got results=%0d falls=%0d expected 3 4", res_id.size(), fall_id.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (fall_id[k] != k % 3 || fall_len[k] != TRIG_C) begin
                    miscompares++;
                    $display("FAIL rr_trig%0d: got id=%0d len=%0d expected id=%0d len=%0d", k, fall_id[k], fall_len[k], k % 3, TRIG_C);
                end
            end
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (res_id[k] != k || res_w[k] != ECHO_LEN || res_to[k] != 0) begin
                    miscompares++;
                    $display("FAIL rr_res%0d: got id=%0d w=%0d to=%0d expected id=%0d w=%0d to=0", k, res_id[k], res_w[k], res_to[k], k, ECHO_LEN);
                end
            end
        end
    endtask

    task automatic test_no_echo();
        bit ok_r, ok_s;
        do_reset();
        set_modes(M_NORMAL, M_NONE, M_NORMAL);
        enable = 1'b1;
        wait_for(Q_RES, 2, ok_r);
        wait_for(Q_RISE, 3, ok_s);
        enable = 1'b0;
        vectors++;
        if (!(ok_r && ok_s)) begin
            miscompares++; $display("FAIL noecho_wait: got results=%0d rises=%0d expected 2 3", res_id.size(), rise_id.size());
        end else begin
            vectors++;
            if (res_id[1] != 1 || res_to[1] != 1 || res_w[1] != 0) begin
                miscompares++; $display("FAIL noecho_res: got id=%0d to=%0d w=%0d expected 1 1 0", res_id[1], res_to[1], res_w[1]);
            end
            vectors++;
            if (res_cyc[1] - fall_cyc[1] != ECHO_TO) begin
                miscompares++; $display("FAIL noecho_lat: got %0d cycles expected %0d", res_cyc[1] - fall_cyc[1], ECHO_TO);
            end
            vectors++;
            if (rise_id[2] != 2 || rise_cyc[2] - res_cyc[1] != GUARD_C) begin
                miscompares++; $display("FAIL noecho_next: got id=%0d gap=%0d expected 2 %0d", rise_id[2], rise_cyc[2] - res_cyc[1], GUARD_C);
            end
        end
    endtask

    task automatic test_stuck_high();
        bit ok;
        int exp_id[4] = '{0, 1, 2, 0};
        int exp_w[4]  = '{ECHO_TO, ECHO_LEN, ECHO_LEN, 0};
        int exp_to[4] = '{1, 0, 0, 1};
        do_reset();
        set_modes(M_STUCK_AFTER, M_NORMAL, M_NORMAL);
        enable = 1'b1;
        wait_for(Q_RES, 1, ok);
        mode[0] = M_HIGH;
        wait_for(Q_RES, 4, ok);
        enable = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL stuck_wait: got results=%0d expected 4", res_id.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (res_id[k] != exp_id[k] || res_w[k] != exp_w[k] || res_to[k] != exp_to[k]) begin
                    miscompares++;
                    $display("FAIL stuck_res%0d: got id=%0d w=%0d to=%0d expected id=%0d w=%0d to=%0d",
                             k, res_id[k], res_w[k], res_to[k], exp_id[k], exp_w[k], exp_to[k]);
                end
            end
            vectors++;
            if (res_cyc[3] - fall_cyc[3] != ECHO_TO) begin
                miscompares++; $display("FAIL stuck_lat: got %0d cycles expected %0d", res_cyc[3] - fall_cyc[3], ECHO_TO);
            end
        end
        mode[0] = M_NONE;
    endtask

    task automatic test_crosstalk();
        bit ok;
        bit seen;
        do_reset();
        set_modes(M_NORMAL, M_NORMAL, M_NORMAL);
        enable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            seen = echo_resp[0];
        end
        for (int k = 0; k < 14; k++) begin
            echo_noise = (k % 2 == 0) ? 3'b110 : 3'b010;
            @(negedge clk);
        end
        echo_noise = '0;
        wait_for(Q_RES, 2, ok);
        enable = 1'b0;
        vectors++;
        if (!(seen && ok)) begin
            miscompares++; $display("FAIL xtalk_wait: got echo_seen=%0d results=%0d expected 1 2", seen, res_id.size());
        end else begin
            vectors++;
            if (res_id[0] != 0 || res_w[0] != ECHO_LEN || res_to[0] != 0) begin
                miscompares++; $display("FAIL xtalk_res0: got id=%0d w=%0d to=%0d expected 0 %0d 0", res_id[0], res_w[0], res_to[0], ECHO_LEN);
            end
            vectors++;
            if (res_id[1] != 1 || res_w[1] != ECHO_LEN || res_to[1] != 0) begin
                miscompares++; $display("FAIL xtalk_res1: got id=%0d w=%0d to=%0d expected 1 %0d 0", res_id[1], res_w[1], res_to[1], ECHO_LEN);
            end
        end
        vectors++;
        if (overlap_cnt != 0) begin
            miscompares++; $display("FAIL trig_overlap: got %0d overlapping cycles expected 0", overlap_cnt);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        bit seen;
        do_reset();
        set_modes(M_NORMAL, M_NORMAL, M_NORMAL);
        enable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            seen = echo_resp[1];
        end
        repeat (5) @(negedge clk);
        enable = 1'b0;
        wait_for(Q_RES, 2, ok);
        repeat (GUARD_C + 30) @(negedge clk);
        vectors++;
        if (!(seen && ok)) begin
            miscompares++; $display("FAIL drop_wait: got echo_seen=%0d results=%0d expected 1 2", seen, res_id.size());
        end else begin
            vectors++;
            if (res_id[1] != 1 || res_w[1] != ECHO_LEN || res_to[1] != 0) begin
                miscompares++; $display("FAIL drop_res: got id=%0d w=%0d to=%0d expected 1 %0d 0", res_id[1], res_w[1], res_to[1], ECHO_LEN);
            end
            vectors++;
            if (busy_fall_cyc - res_cyc[1] != GUARD_C) begin
                miscompares++; $display("FAIL drop_guard: got busy low %0d cycles after result expected %0d", busy_fall_cyc - res_cyc[1], GUARD_C);
            end
        end
        vectors++;
        if (busy !== 1'b0 || rise_id.size() != 2 || res_id.size() != 2) begin
            miscompares++;
            $display("FAIL drop_idle: got busy=%b trigs=%0d results=%0d expected 0 2 2", busy, rise_id.size(), res_id.size());
        end
    endtask

    task automatic test_reset_mid_trig();
        bit seen, ok;
        int nres, nrise;
        do_reset();
        set_modes(M_NORMAL, M_NORMAL, M_NORMAL);
        enable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (trig === 3'b010) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        reset = 1'b1;
        nres = res_id.size();
        @(negedge clk);
        vectors++;
        if (!seen || trig !== 3'b000 || busy !== 1'b0 || meas_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got seen=%0d trig=%b busy=%b valid=%b expected 1 000 0 0", seen, trig, busy, meas_valid);
        end
        @(negedge clk);
        nrise = rise_id.size();
        reset = 1'b0;
        wait_for(Q_RISE, nrise + 1, ok);
        enable = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL rst_restart_wait: got rises=%0d expected %0d", rise_id.size(), nrise + 1);
        end else if (rise_id[nrise] != 0) begin
            miscompares++; $display("FAIL rst_restart_id: got %0d expected 0", rise_id[nrise]);
        end
        vectors++;
        if (res_id.size() != nres) begin
            miscompares++; $display("FAIL rst_no_result: got %0d results expected %0d", res_id.size(), nres);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_modes(M_NONE, M_NONE, M_NONE);
        test_reset();
        test_round_robin();
        test_no_echo();
        test_stuck_high();
        test_crosstalk();
        test_enable_drop();
        test_reset_mid_trig();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
